div32_seq: RTL



---
 rtl/div32_pkg.sv | 22 ++
 rtl/div32_step.sv | 33 +++
 rtl/div32_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div32_pkg.sv
// Shared arithmetic package for the sign-magnitude datapath.
// Holds the divider FSM encoding, sign-magnitude field positions and a packing helper.
package div32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SM_SIGN = 31;
  localparam int MAG_W   = 31;

  localparam logic [MAG_W-1:0] MAG_MAX  = 31'h7FFFFFFF;
  localparam logic [4:0]       CNT_INIT = 5'd30;

  // Build a sign-magnitude word; a zero magnitude always carries a + sign so -0 never leaves the unit.
  function automatic logic [31:0] sm_pack(input logic sign, input logic [MAG_W-1:0] mag);
    return {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/div32_step.sv
// One restoring-division iteration on 31-bit magnitudes.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the divisor
// and keeps or restores the result, producing one quotient bit.
module div32_step
  import div32_pkg::*;
(
  input  logic [MAG_W+1:0] i_r,
  input  logic [MAG_W-1:0] i_q,
  input  logic [MAG_W-1:0] i_d,
  output logic [MAG_W+1:0] o_r,
  output logic [MAG_W-1:0] o_q
);

  logic [MAG_W+1:0] w_shift;
  logic [MAG_W+1:0] w_trial;
  logic             w_unused;

  // The partial remainder never exceeds 32 significant bits, so its top bit is not shifted in.
  assign w_unused = i_r[MAG_W+1];
  assign w_shift  = {i_r[MAG_W:0], i_q[MAG_W-1]};
  assign w_trial  = w_shift - {2'b00, i_d};

  // Keep the difference when it is non-negative (quotient bit 1), else restore (quotient bit 0).
  always_comb begin
    o_r = w_shift;
    o_q = {i_q[MAG_W-2:0], 1'b0};
    if (!w_trial[MAG_W+1]) begin
      o_r    = w_trial;
      o_q[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit sign-magnitude divider.
// Restoring division on the 31-bit magnitudes, one quotient bit per cycle, with a
// start/done handshake. Results are registered and held until the next divide completes.
module div32_seq
  import div32_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MAG_W+1:0] r_rem;
  logic [MAG_W-1:0] r_q;
  logic [MAG_W-1:0] r_d;
  logic [4:0]       r_cnt;
  logic             r_sq;
  logic             r_sr;
  logic             r_dz;
  logic [31:0]      r_quot;
  logic [31:0]      r_remo;
  logic             r_dbz;

  logic [MAG_W+1:0] w_rem_nxt;
  logic [MAG_W-1:0] w_q_nxt;
  logic             w_div_zero;
  logic             w_early_zero;

  // +0 and -0 divisors are both zero.
  assign w_div_zero   = ~|divisor[MAG_W-1:0];
  assign w_early_zero = EARLY_ZERO && w_div_zero;

  div32_step u_step (
    .i_r (r_rem),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_rem_nxt),
    .o_q (w_q_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE only, iterate in CALC until the count runs out, DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_early_zero ? DONE : CALC;
      CALC:    if (r_cnt == 5'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_dz   <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_d   <= divisor[MAG_W-1:0];
            r_q   <= dividend[MAG_W-1:0];
            r_rem <= '0;
            r_cnt <= CNT_INIT;
            r_sq  <= dividend[SM_SIGN] ^ divisor[SM_SIGN];
            r_sr  <= dividend[SM_SIGN];
            r_dz  <= w_div_zero;
            if (w_early_zero) begin
              r_quot <= {dividend[SM_SIGN] ^ divisor[SM_SIGN], MAG_MAX};
              r_remo <= sm_pack(dividend[SM_SIGN], dividend[MAG_W-1:0]);
              r_dbz  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            // With a zero divisor every trial succeeds and the remainder ends up holding
            // the dividend magnitude, so only the quotient needs forcing.
            r_remo <= sm_pack(r_sr, w_rem_nxt[MAG_W-1:0]);
            if (r_dz) begin
              r_quot <= {r_sq, MAG_MAX};
              r_dbz  <= 1'b1;
            end else begin
              r_quot <= sm_pack(r_sq, w_q_nxt);
              r_dbz  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule
